// File: rtl/module_2_pkg.sv
// Shared encodings and defaults for module_2, the B+C consumer stage of the
// dataflow pipeline.
package module_2_pkg;

   localparam int N_DEF  = 5;
   localparam int DW_DEF = 32;
   localparam int AW_DEF = 3;

   // One-hot control states: idle/start, loop test, transfer.
   typedef enum logic [2:0] {
      ST_S1 = 3'd1,
      ST_S2 = 3'd2,
      ST_S3 = 3'd4
   } state_t;

endpackage

// File: rtl/module_2_if.sv
// Handshake, FIFO-read and D-memory bus of module_2. The master side is the
// consumer block itself; the slave side is the surrounding pipeline.
interface module_2_if
   import module_2_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) ();

   logic          ap_start;
   logic          ap_done;
   logic          ap_continue;
   logic          ap_idle;
   logic          ap_ready;
   logic [DW-1:0] B_dout;
   logic          B_empty_n;
   logic          B_read;
   logic [DW-1:0] C_dout;
   logic          C_empty_n;
   logic          C_read;
   logic [AW-1:0] D_address0;
   logic          D_ce0;
   logic          D_we0;
   logic [DW-1:0] D_d0;
   logic [DW-1:0] sum_out;

   modport master (
      input  ap_start, ap_continue,
      input  B_dout, B_empty_n, C_dout, C_empty_n,
      output ap_done, ap_idle, ap_ready,
      output B_read, C_read,
      output D_address0, D_ce0, D_we0, D_d0,
      output sum_out
   );

   modport slave (
      output ap_start, ap_continue,
      output B_dout, B_empty_n, C_dout, C_empty_n,
      input  ap_done, ap_idle, ap_ready,
      input  B_read, C_read,
      input  D_address0, D_ce0, D_we0, D_d0,
      input  sum_out
   );

endinterface

// File: rtl/module_2.sv
// Consumer stage: pops B and C FIFOs, writes D[i] = B + C under ap_ctrl_chain.
// Define MODULE_2_SUM_EN to build the running-sum accumulator behind sum_out.
module module_2
   import module_2_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic       ap_clk,
   input  logic       ap_rst,
   module_2_if.master bus
);

   // One extra counter bit so i can reach N even when 2^AW == N.
   localparam int CW = AW + 1;

   state_t        state;
   logic [CW-1:0] i;
   logic          ap_done_reg;
   logic          start_ok;
   logic          done_pulse;
   logic          xfer;
   logic [DW-1:0] sum_d;

   assign start_ok   = (state == ST_S1) && bus.ap_start && !ap_done_reg;
   assign done_pulse = (state == ST_S2) && (i == CW'(N));
   assign xfer       = (state == ST_S3) && bus.B_empty_n && bus.C_empty_n;
   assign sum_d      = bus.B_dout + bus.C_dout;

   assign bus.ap_done    = done_pulse | ap_done_reg;
   assign bus.ap_ready   = done_pulse;
   assign bus.ap_idle    = (state == ST_S1) && !bus.ap_start;
   assign bus.B_read     = xfer;
   assign bus.C_read     = xfer;
   assign bus.D_ce0      = xfer;
   assign bus.D_we0      = xfer;
   assign bus.D_address0 = i[AW-1:0];
   assign bus.D_d0       = sum_d;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state       <= ST_S1;
         i           <= '0;
         ap_done_reg <= 1'b0;
      end else begin
         // Continue wins over a same-cycle done so the ack is never lost.
         if (bus.ap_continue)
            ap_done_reg <= 1'b0;
         else if (done_pulse)
            ap_done_reg <= 1'b1;

         case (state)
            ST_S1: begin
               if (start_ok) begin
                  i     <= '0;
                  state <= ST_S2;
               end
            end
            ST_S2: state <= done_pulse ? ST_S1 : ST_S3;
            ST_S3: begin
               if (xfer) begin
                  i     <= i + CW'(1);
                  state <= ST_S2;
               end
            end
            default: state <= ST_S1;
         endcase
      end
   end

`ifdef MODULE_2_SUM_EN
   logic [DW-1:0] acc;

   always_ff @(posedge ap_clk) begin
      if (ap_rst)
         acc <= '0;
      else if (start_ok)
         acc <= '0;
      else if (xfer)
         acc <= acc + sum_d;
   end

   assign bus.sum_out = acc;
`else
   assign bus.sum_out = '0;
`endif

endmodule

// File: tb/tb_module_2.sv
// Scoreboard bench for module_2: directed B/C vectors, queued expected D
// writes and done events, checked by an independent monitor.
module tb_module_2;

   localparam int N   = 5;
   localparam int DW  = 32;
   localparam int AW  = 3;
   localparam int LAT = 2 * N + 1;  // accept cycle counted as the first of 2N+2
   localparam int STALL = 5;

`ifdef MODULE_2_SUM_EN
   localparam bit SUM_EN = 1'b1;
`else
   localparam bit SUM_EN = 1'b0;
`endif

   logic ap_clk = 1'b0;
   logic ap_rst;
   always #5 ap_clk = ~ap_clk;

   module_2_if #(.DW(DW), .AW(AW)) bus ();

   module_2 #(.N(N), .DW(DW), .AW(AW)) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus)
   );

   localparam logic [DW-1:0] B_TAB [6][5] = '{
      '{32'd9, 32'd18, 32'd27, 32'd36, 32'd45},
      '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500},
      '{32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'd6, 32'd7},
      '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1},
      '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3},
      '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5}
   };
   localparam logic [DW-1:0] C_TAB [6][5] = '{
      '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10},
      '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5},
      '{32'd2, 32'h8000_0000, 32'd5, 32'd6, 32'd7},
      '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1},
      '{32'd4, 32'd4, 32'd4, 32'd4, 32'd4},
      '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1}
   };
   localparam logic [DW-1:0] D_TAB [6][5] = '{
      '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55},
      '{32'd101, 32'd202, 32'd303, 32'd404, 32'd505},
      '{32'd1, 32'd0, 32'd10, 32'd12, 32'd14},
      '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2},
      '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7},
      '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6}
   };
   localparam logic [DW-1:0] SUM_TAB [6] = '{32'd165, 32'd1515, 32'd37, 32'd10, 32'd35, 32'd0};

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      int            lat;
      logic [DW-1:0] sum;
   } done_t;

   wr_t           exp_wr[$];
   done_t         exp_done[$];
   logic [DW-1:0] bq[$];
   logic [DW-1:0] cq[$];

   int checks = 0;
   int errors = 0;
   int c_pops = 0;
   int skip   = 0;
   int rem    = 0;
   bit stall_arm = 1'b0;
   bit b_pop, c_pop;
   int cyc = 0;
   int accept_cyc = 0;
   bit running = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit stalled();
      return (skip == 0) && (rem > 0);
   endfunction

   task automatic drive_fifo();
      bus.B_empty_n = (bq.size() != 0);
      bus.B_dout    = (bq.size() != 0) ? bq[0] : '0;
      bus.C_empty_n = (cq.size() != 0) && !stalled();
      bus.C_dout    = (cq.size() != 0) ? cq[0] : '0;
   endtask

   // FIFO model: pops are sampled mid-cycle and applied just after the edge.
   initial begin
      forever begin
         @(negedge ap_clk);
         b_pop = bus.B_read;
         c_pop = bus.C_read;
         @(posedge ap_clk);
         #1;
         if (skip > 0) skip--;
         else if (rem > 0) rem--;
         if (b_pop && bq.size() != 0) void'(bq.pop_front());
         if (c_pop && cq.size() != 0) begin
            void'(cq.pop_front());
            c_pops++;
            // Stall spans the five S3 cycles following the S2 after element 1.
            if (stall_arm && c_pops == 2) begin
               skip      = 1;
               rem       = STALL;
               stall_arm = 1'b0;
            end
         end
         drive_fifo();
      end
   end

   // Monitor: tracks start acceptance and pops expectations on DUT events.
   always @(negedge ap_clk) begin
      wr_t   w;
      done_t d;
      cyc++;
      if (ap_rst) begin
         running = 1'b0;
      end else begin
         if (!running && bus.ap_start && !bus.ap_done) begin
            running    = 1'b1;
            accept_cyc = cyc;
         end
         if (stalled())
            check("stall_quiet", 64'({bus.B_read, bus.C_read, bus.D_we0}), 64'd0);
         if (bus.D_we0) begin
            check("write_pops_both", 64'({bus.D_ce0, bus.B_read, bus.C_read}), 64'd7);
            check("write_expected", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) begin
               w = exp_wr.pop_front();
               check("d_addr", 64'(bus.D_address0), 64'(w.addr));
               check("d_data", 64'(bus.D_d0), 64'(w.data));
            end
         end
         if (bus.ap_ready) begin
            check("done_with_ready", 64'(bus.ap_done), 64'd1);
            check("done_expected", 64'(exp_done.size() != 0), 64'd1);
            if (exp_done.size() != 0) begin
               d = exp_done.pop_front();
               check("done_latency", 64'(cyc - accept_cyc), 64'(d.lat));
               check("done_sum", 64'(bus.sum_out), SUM_EN ? 64'(d.sum) : 64'd0);
            end
            running = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge ap_clk);
      #2;
   endtask

   task automatic load(input int r, input int n_wr, input bit with_done, input int lat,
                       input bit stall);
      bq.delete();
      cq.delete();
      c_pops    = 0;
      skip      = 0;
      rem       = 0;
      stall_arm = stall;
      for (int k = 0; k < N; k++) begin
         bq.push_back(B_TAB[r][k]);
         cq.push_back(C_TAB[r][k]);
      end
      for (int k = 0; k < n_wr; k++)
         exp_wr.push_back('{addr: AW'(k), data: D_TAB[r][k]});
      if (with_done)
         exp_done.push_back('{lat: lat, sum: SUM_TAB[r]});
      drive_fifo();
   endtask

   task automatic start_run();
      tick();
      bus.ap_start = 1'b1;
      tick();
      bus.ap_start = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      bit found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge ap_clk);
         if (bus.ap_ready) found = 1'b1;
      end
      check(name, 64'(found), 64'd1);
   endtask

   initial begin
      int  seen;
      bus.ap_start    = 1'b0;
      bus.ap_continue = 1'b1;
      ap_rst          = 1'b1;
      drive_fifo();
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      check("rst_idle", 64'(bus.ap_idle), 64'd1);
      check("rst_done", 64'(bus.ap_done), 64'd0);
      check("rst_ready", 64'(bus.ap_ready), 64'd0);
      check("rst_we", 64'({bus.D_we0, bus.B_read, bus.C_read}), 64'd0);
      check("rst_sum", 64'(bus.sum_out), 64'd0);
      check("rst_addr", 64'(bus.D_address0), 64'd0);
      tick();
      ap_rst = 1'b0;

      // Nominal, single-FIFO stall, and carry-wrap runs.
      load(0, N, 1'b1, LAT, 1'b0);
      start_run();
      wait_ready("nominal_done");
      tick();
      load(1, N, 1'b1, LAT + STALL, 1'b1);
      start_run();
      wait_ready("stall_done");
      tick();
      load(2, N, 1'b1, LAT, 1'b0);
      start_run();
      wait_ready("wrap_done");

      // Done hold: no continue, start reasserted with fresh data available.
      tick();
      bus.ap_continue = 1'b0;
      load(3, N, 1'b1, LAT, 1'b0);
      start_run();
      wait_ready("hold_run_done");
      tick();
      load(4, N, 1'b1, LAT, 1'b0);
      bus.ap_start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge ap_clk);
         check("hold_done", 64'(bus.ap_done), 64'd1);
         check("hold_idle", 64'(bus.ap_idle), 64'd0);
         check("hold_no_read", 64'({bus.B_read, bus.D_we0}), 64'd0);
         check("hold_sum", 64'(bus.sum_out), SUM_EN ? 64'd10 : 64'd0);
      end
      tick();
      bus.ap_continue = 1'b1;
      @(negedge ap_clk);
      check("cont_cycle_done", 64'(bus.ap_done), 64'd1);
      tick();
      tick();
      bus.ap_start = 1'b0;
      wait_ready("restart_done");

      // Reset while stalled in transfer after two writes.
      tick();
      load(5, 2, 1'b0, 0, 1'b1);
      start_run();
      seen = 0;
      for (int k = 0; k < 50 && seen < 2; k++) begin
         @(negedge ap_clk);
         if (bus.D_we0) seen++;
      end
      check("reset_pre_writes", 64'(seen), 64'd2);
      tick();
      tick();
      ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("mid_rst_done", 64'(bus.ap_done), 64'd0);
      check("mid_rst_idle", 64'(bus.ap_idle), 64'd1);
      check("mid_rst_sum", 64'(bus.sum_out), 64'd0);
      check("mid_rst_addr", 64'(bus.D_address0), 64'd0);
      tick();
      load(0, N, 1'b1, LAT, 1'b0);
      start_run();
      wait_ready("post_rst_done");

      tick();
      tick();
      check("wr_drained", 64'(exp_wr.size()), 64'd0);
      check("done_drained", 64'(exp_done.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
